solver_ctrl_avalon: RTL

SOLVER_CTRL_AVALON -- requirements
Module: solver_ctrl_avalon

---
 rtl/solver_ctrl_avalon.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/solver_ctrl_avalon.sv
// Avalon-MM control block for the alignment solver: sequence load, start/abort, status, result.
// Optional RUN watchdog enabled by defining SOLVER_TIMEOUT_EN.
module solver_ctrl_avalon #(
  parameter int LEN1           = 10,
  parameter int LEN2           = 9,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [5:0]                 avm_main_address,
  input  logic                       avm_main_write,
  input  logic [63:0]                avm_main_writedata,
  input  logic                       avm_main_read,
  output logic [63:0]                avm_main_readdata,
  output logic [2*LEN1-1:0]          seq1_o,
  output logic [2*LEN2-1:0]          seq2_o,
  output logic                       solver_rst_o,
  input  logic                       solver_finished_i,
  input  logic [2*(LEN1+LEN2)-1:0]   solver_result_i
);

  localparam int RW = 2 * (LEN1 + LEN2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_hold;
  logic [15:0]     r_cnt;
  logic            r_done;
  logic [RW-1:0]   r_res;
  logic [2*LEN1-1:0] r_seq1;
  logic [2*LEN2-1:0] r_seq2;

  logic            w_ctrl_wr;
  logic            w_start;
  logic            w_abort;
  logic            w_busy;
  logic            w_go;
  logic            w_fin;
  logic [15:0]     w_cnt_inc;
  logic            w_tmo;
  logic            w_to;

  assign w_ctrl_wr = avm_main_write && (avm_main_address == 6'd0);
  assign w_start   = w_ctrl_wr && avm_main_writedata[0];
  assign w_abort   = w_ctrl_wr && avm_main_writedata[1];
  assign w_busy    = (r_state == S_HOLD) || (r_state == S_RUN);
  assign w_go      = w_start && !w_abort && !w_busy;
  assign w_fin     = (r_state == S_RUN) && solver_finished_i && !w_abort;
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

`ifdef SOLVER_TIMEOUT_EN
  localparam logic [31:0] TMO = TIMEOUT_CYCLES;
  logic r_to;

  // Watchdog fires on the RUN cycle whose count reaches the limit.
  assign w_tmo = ({16'd0, w_cnt_inc} >= TMO);
  assign w_to  = r_to;

  // Timeout flag: cleared by a new start, set when the watchdog wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to <= 1'b0;
    end else if (w_go) begin
      r_to <= 1'b0;
    end else if (r_state == S_RUN && w_next == S_TIMEOUT) begin
      r_to <= 1'b1;
    end
  end
`else
  assign w_tmo = 1'b0;
  assign w_to  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: abort beats everything, finish beats watchdog.
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (w_start) w_next = S_HOLD;
        end
        S_HOLD: begin
          if (r_hold) w_next = S_RUN;
        end
        S_RUN: begin
          if (solver_finished_i) w_next = S_DONE;
          else if (w_tmo) w_next = S_TIMEOUT;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Solver is held in reset everywhere but RUN.
  always_comb begin
    solver_rst_o = (r_state != S_RUN);
  end

  // Datapath: hold phase, run counter, done flag, result and sequences.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold <= 1'b0;
      r_cnt  <= 16'd0;
      r_done <= 1'b0;
      r_res  <= '0;
      r_seq1 <= '0;
      r_seq2 <= '0;
    end else begin
      r_hold <= (r_state == S_HOLD) && !r_hold;
      if (w_go) begin
        r_cnt  <= 16'd0;
        r_done <= 1'b0;
      end else begin
        if (r_state == S_RUN) r_cnt <= w_cnt_inc;
        if (w_fin) r_done <= 1'b1;
      end
      if (w_fin) r_res <= solver_result_i;
      if (avm_main_write && !w_busy) begin
        if (avm_main_address == 6'd1)
          r_seq1 <= avm_main_writedata[2*LEN1-1:0];
        if (avm_main_address == 6'd2)
          r_seq2 <= avm_main_writedata[2*LEN2-1:0];
      end
    end
  end

  assign seq1_o = r_seq1;
  assign seq2_o = r_seq2;

  // Read mux straight from registers, so a same-cycle write is not visible.
  always_comb begin
    avm_main_readdata = 64'd0;
    unique case (1'b1)
      avm_main_read && (avm_main_address == 6'd3):
        avm_main_readdata = {16'd0, r_cnt, 29'd0, w_to, r_done, w_busy};
      avm_main_read && (avm_main_address == 6'd4):
        avm_main_readdata = {{(64-RW){1'b0}}, r_res};
      default: avm_main_readdata = 64'd0;
    endcase
  end

endmodule
